led_bar_engine: RTL and testbench

//  Parametrised LED-bar pattern engine: successor to the fixed 16-LED controller.

---
 rtl/led_bar_engine.sv | 168 ++++++++++++++++
 tb/tb_led_bar_engine.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/led_bar_engine.sv
// LED-bar pattern engine: BOUNCE / LEVEL / CHASE / PAUSE patterns driven by a
// programmable tick generator, with button-adjusted bar level and clamped update period.
module led_bar_engine #(
  parameter int unsigned NUM_LEDS       = 16,
  parameter int unsigned PERIOD_W       = 32,
  parameter int unsigned PERIOD_DEFAULT = 6250000,
  parameter int unsigned PERIOD_STEP    = 500000,
  parameter int unsigned PERIOD_MIN     = 500000,
  parameter int unsigned PERIOD_MAX     = 200000000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic [1:0]          i_mode,
  input  logic                i_incr,
  input  logic                i_decr,
  output logic [NUM_LEDS-1:0] o_leds,
  output logic                o_tick,
  output logic [PERIOD_W-1:0] o_period
);

  localparam int unsigned HALF  = NUM_LEDS / 2;
  localparam int unsigned POS_W = $clog2(NUM_LEDS);
  localparam int unsigned LVL_W = $clog2(NUM_LEDS + 1);
  localparam int unsigned PW1   = PERIOD_W + 1;

  localparam logic [PERIOD_W-1:0] P_DEFAULT = PERIOD_W'(PERIOD_DEFAULT);
  localparam logic [PERIOD_W-1:0] P_STEP    = PERIOD_W'(PERIOD_STEP);
  localparam logic [PERIOD_W-1:0] P_MIN     = PERIOD_W'(PERIOD_MIN);
  localparam logic [PERIOD_W-1:0] P_MAX     = PERIOD_W'(PERIOD_MAX);
  localparam logic [PW1-1:0]      X_STEP    = PW1'(PERIOD_STEP);
  localparam logic [PW1-1:0]      X_MIN     = PW1'(PERIOD_MIN);
  localparam logic [PW1-1:0]      X_MAX     = PW1'(PERIOD_MAX);

  typedef enum logic [1:0] {
    MODE_BOUNCE = 2'd0,
    MODE_LEVEL  = 2'd1,
    MODE_CHASE  = 2'd2,
    MODE_PAUSE  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  mode_e mode;
  assign mode = mode_e'(i_mode);

  logic [PERIOD_W-1:0] count, count_nxt;
  logic [PERIOD_W-1:0] period, period_nxt;
  logic                tick, tick_nxt;
  logic [POS_W-1:0]    pos, pos_nxt;
  dir_e                dir, dir_nxt;
  logic [LVL_W-1:0]    level, level_nxt;
  logic [NUM_LEDS-1:0] chase, chase_nxt;
  logic [NUM_LEDS-1:0] leds, leds_nxt;

  logic                incr_req, decr_req;
  logic [PERIOD_W-1:0] period_faster, period_slower;
  logic [PW1-1:0]      period_x;
  logic [NUM_LEDS-1:0] bounce_pat, level_pat;

  assign incr_req = i_incr & ~i_decr;
  assign decr_req = i_decr & ~i_incr;

  // Saturating period arithmetic is done one bit wider so the clamps never wrap.
  always_comb begin
    period_x      = {1'b0, period};
    period_faster = (period_x >= X_MIN + X_STEP) ? period - P_STEP : P_MIN;
    period_slower = (period_x + X_STEP > X_MAX)  ? P_MAX : period + P_STEP;
  end

  always_comb begin
    count_nxt = count + PERIOD_W'(1);
    tick_nxt  = 1'b0;
    if (mode == MODE_PAUSE) begin
      count_nxt = '0;
    end else if (count >= period - PERIOD_W'(1)) begin
      count_nxt = '0;
      tick_nxt  = 1'b1;
    end
  end

  always_comb begin
    pos_nxt    = pos;
    dir_nxt    = dir;
    level_nxt  = level;
    chase_nxt  = chase;
    period_nxt = period;
    if (tick) begin
      case (mode)
        MODE_BOUNCE: begin
          if (pos == POS_W'(NUM_LEDS - 1)) begin
            pos_nxt = POS_W'(NUM_LEDS - 2);
            dir_nxt = DIR_DOWN;
          end else if (pos == '0) begin
            pos_nxt = POS_W'(1);
            dir_nxt = DIR_UP;
          end else if (dir == DIR_UP) begin
            pos_nxt = pos + POS_W'(1);
          end else begin
            pos_nxt = pos - POS_W'(1);
          end
          if (incr_req)      period_nxt = period_faster;
          else if (decr_req) period_nxt = period_slower;
        end
        MODE_LEVEL: begin
          if (incr_req && level != LVL_W'(NUM_LEDS)) level_nxt = level + LVL_W'(1);
          else if (decr_req && level != '0)          level_nxt = level - LVL_W'(1);
        end
        MODE_CHASE: begin
          chase_nxt = {chase[NUM_LEDS-2:0], chase[NUM_LEDS-1]};
          if (incr_req)      period_nxt = period_faster;
          else if (decr_req) period_nxt = period_slower;
        end
        default: ;
      endcase
    end
  end

  // Bounce lights the span between pos and the centre line; level lights the top bits.
  always_comb begin
    bounce_pat = '0;
    level_pat  = '0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (32'(pos) < HALF) bounce_pat[i] = (i >= 32'(pos)) && (i < HALF);
      else                 bounce_pat[i] = (i >= HALF) && (i <= 32'(pos));
      level_pat[i] = (i + 32'(level)) >= NUM_LEDS;
    end
  end

  always_comb begin
    leds_nxt = leds;
    case (mode)
      MODE_BOUNCE: leds_nxt = bounce_pat;
      MODE_LEVEL:  leds_nxt = level_pat;
      MODE_CHASE:  leds_nxt = chase;
      default:     leds_nxt = leds;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      count  <= '0;
      tick   <= 1'b0;
      period <= P_DEFAULT;
      pos    <= POS_W'(HALF - 1);
      dir    <= DIR_UP;
      level  <= LVL_W'(HALF);
      chase  <= NUM_LEDS'(1);
      leds   <= '0;
    end else begin
      count  <= count_nxt;
      tick   <= tick_nxt;
      period <= period_nxt;
      pos    <= pos_nxt;
      dir    <= dir_nxt;
      level  <= level_nxt;
      chase  <= chase_nxt;
      leds   <= leds_nxt;
    end
  end

  assign o_leds   = leds;
  assign o_tick   = tick;
  assign o_period = period;

endmodule

// File: tb/tb_led_bar_engine.sv
// Directed bench for led_bar_engine with 8 LEDs and a short period (default 4, step 2, 2..8).
module tb_led_bar_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode;
  logic        incr, decr;
  logic [7:0]  leds;
  logic        tick;
  logic [31:0] period;

  int vectors = 0;
  int miscompares = 0;
  int n;

  led_bar_engine #(
    .NUM_LEDS(8),
    .PERIOD_W(32),
    .PERIOD_DEFAULT(4),
    .PERIOD_STEP(2),
    .PERIOD_MIN(2),
    .PERIOD_MAX(8)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_mode(mode),
    .i_incr(incr),
    .i_decr(decr),
    .o_leds(leds),
    .o_tick(tick),
    .o_period(period)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Returns the number of falling edges until o_tick is seen high (bounded).
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (tick !== 1'b1 && cnt < 40);
    chk("tick_seen", 32'(tick), 32'd1);
  endtask

  task automatic settle2;
    @(negedge clk);
    @(negedge clk);
  endtask

  logic [7:0] bseq [16] = '{8'h10, 8'h30, 8'h70, 8'hF0, 8'h70, 8'h30, 8'h10, 8'h08,
                            8'h0C, 8'h0E, 8'h0F, 8'h0E, 8'h0C, 8'h08, 8'h10, 8'h30};
  logic [7:0] lup  [6]  = '{8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'hFF};
  logic [7:0] ldn  [9]  = '{8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00};
  int         igap [2]  = '{2, 1};
  logic [31:0] iper[2]  = '{32'd2, 32'd2};
  int         dgap [4]  = '{1, 3, 5, 7};
  logic [31:0] dper[4]  = '{32'd4, 32'd6, 32'd8, 32'd8};
  logic [7:0] cseq [9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};

  initial begin
    rst_n = 1'b0; mode = 2'd0; incr = 1'b0; decr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_leds", 32'(leds), 32'h00);
    chk("rst_period", period, 32'd4);
    chk("rst_tick", 32'(tick), 32'd0);

    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_leds", 32'(leds), 32'h08);
    chk("rel_tick", 32'(tick), 32'd0);

    for (int k = 0; k < 16; k++) begin
      wait_tick(n);
      chk($sformatf("bounce_gap[%0d]", k), 32'(n), (k == 0) ? 32'd3 : 32'd2);
      settle2();
      chk($sformatf("bounce[%0d]", k), 32'(leds), 32'(bseq[k]));
    end

    mode = 2'd1; incr = 1'b1;
    @(negedge clk);
    chk("lvl_switch", 32'(leds), 32'hF0);
    for (int k = 0; k < 6; k++) begin
      wait_tick(n); settle2();
      chk($sformatf("lvl_up[%0d]", k), 32'(leds), 32'(lup[k]));
    end
    incr = 1'b0; decr = 1'b1;
    for (int k = 0; k < 9; k++) begin
      wait_tick(n); settle2();
      chk($sformatf("lvl_dn[%0d]", k), 32'(leds), 32'(ldn[k]));
    end
    decr = 1'b0; incr = 1'b1;
    wait_tick(n); settle2();
    chk("lvl_one", 32'(leds), 32'h80);
    decr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_tick(n); settle2();
      chk($sformatf("lvl_both[%0d]", k), 32'(leds), 32'h80);
    end
    incr = 1'b0; decr = 1'b0;
    chk("lvl_period", period, 32'd4);

    mode = 2'd0; incr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      wait_tick(n);
      chk($sformatf("inc_gap[%0d]", k), 32'(n), 32'(igap[k]));
      @(negedge clk);
      chk($sformatf("inc_period[%0d]", k), period, iper[k]);
    end
    incr = 1'b0; decr = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_tick(n);
      chk($sformatf("dec_gap[%0d]", k), 32'(n), 32'(dgap[k]));
      @(negedge clk);
      chk($sformatf("dec_period[%0d]", k), period, dper[k]);
    end
    decr = 1'b0;

    mode = 2'd2;
    for (int k = 0; k < 9; k++) begin
      wait_tick(n); settle2();
      chk($sformatf("chase[%0d]", k), 32'(leds), 32'(cseq[k]));
    end
    mode = 2'd1;
    @(negedge clk);
    chk("chase_to_lvl", 32'(leds), 32'h80);
    wait_tick(n);
    @(negedge clk);
    mode = 2'd2;
    @(negedge clk);
    chk("chase_kept", 32'(leds), 32'h02);
    wait_tick(n); settle2();
    chk("chase_next", 32'(leds), 32'h04);

    mode = 2'd0;
    @(negedge clk);
    chk("bounce_back", 32'(leds), 32'h08);
    wait_tick(n); settle2();
    chk("bounce_down", 32'(leds), 32'h0C);
    settle2();
    mode = 2'd3;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("pause_leds[%0d]", k), 32'(leds), 32'h0C);
      chk($sformatf("pause_tick[%0d]", k), 32'(tick), 32'd0);
    end
    mode = 2'd0;
    wait_tick(n); settle2();
    chk("resume", 32'(leds), 32'h0E);

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_leds", 32'(leds), 32'h00);
    chk("async_tick", 32'(tick), 32'd0);
    chk("async_period", period, 32'd4);
    #20 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
